cm_rx_fifo: RTL and testbench
=============================

# cm_rx_fifo

Receive stage for the Xmega→FPGA chip interconnect. Captures each byte the Xmega presents on CM[7:0] when it raises CLK_inter, brings it into the CLK_50 domain and buffers it in a show-ahead FIFO. Bytes leave on a valid/ready stream to downstream FPGA logic (LED/7-segment display, SPI flash writer). Overflow is flagged and counted, never silent.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..256
- CLK_50  input  1  system clock, 50 MHz; all state is in this domain
- RST_n  input  1  reset; asynchronous, active-low; deassertion is synchronous to CLK_50 in the top level
- CM  input  8  interconnect data from Xmega PORTA; asynchronous to CLK_50
- CLK_inter  input  1  byte strobe from Xmega PC0; rising edge = byte valid; asynchronous
- rx_data  output  8  FIFO head byte; meaningful only while rx_valid=1
- rx_valid  output  1  FIFO non-empty
- rx_ready  input  1  consumer accepts head; pop occurs on an edge where rx_valid & rx_ready
- fifo_level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a byte was dropped because the FIFO was full
- drop_count  output  8  dropped bytes, saturates at 255
- clr_ovf  input  1  synchronous pulse; clears overflow and drop_count
- LED  output  8  debug view (see Configuration)

## Operation
- CM[7:0] and CLK_inter each pass through a 2-flop synchronizer (s1, s2). A third flop s3 on CLK_inter gives the edge detect: strobe = s2 & ~s3 & armed.
- armed: reset 0; sets on the first cycle with s2=0 for CLK_inter and stays set. CLK_inter held high through reset therefore produces no byte.
- On strobe, the synchronized CM value (s2) is written at the tail, provided the FIFO is not full or a pop occurs on the same edge.
- Write when full and no pop: byte is dropped, overflow←1, drop_count←min(drop_count+1,255); FIFO contents unchanged.
- Simultaneous push and pop: both occur; fifo_level is unchanged; a full FIFO stays full with no drop.
- Push into an empty FIFO: no bypass; the byte appears on rx_data one edge later.
- clr_ovf with a drop on the same edge: overflow=1, drop_count=1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. fifo_level is a separate counter: +1 on push only, −1 on pop only.
- rx_data is driven from memory at the read pointer; it is stable while rx_valid=1 and rx_ready=0.
- Xmega protocol requirements: CM stable ≥3 CLK_50 periods before and after the CLK_inter rising edge; CLK_inter high and low phases each ≥3 CLK_50 periods. The block does not check these requirements.

## Timing
- Reset values: rx_valid=0, fifo_level=0, overflow=0, drop_count=0, LED=8'h00. rx_data=8'h00 (memory need not be reset; rx_data is muxed to 0 while empty).
- Latency: rx_valid rises 2 CLK_50 edges after the first edge that samples CLK_inter high, or 3 edges if the synchronizer resolves late.
- Pop: rx_valid/fifo_level update on the same edge that pops; the next head is presented on that edge.
- One strobe per CLK_inter rising edge. Throughput is limited by the ≥6-cycle strobe period, so a consumer holding rx_ready=1 never overflows.
- RST_n asserted mid-operation: all buffered bytes are discarded and outputs return to reset values immediately (asynchronous).

## Configuration
- CM_RX_LED_EN defined: LED shows the last byte accepted into the FIFO (registered on push). LED is forced to 8'hFF for as long as overflow=1.
- CM_RX_LED_EN undefined: LED is tied to 8'h00 and the LED register is not built.

## Test plan
- Reset with CLK_inter held high, then release and keep it high for 20 cycles -> rx_valid stays 0, fifo_level=0; a later low→high edge with CM=8'hA5 -> rx_valid=1 within 3 edges, rx_data=8'hA5.
- Send 8'h01..8'h05 with rx_ready=0, then set rx_ready=1 -> fifo_level reaches 5; bytes pop in order 01..05; rx_valid falls after the 5th pop.
- DEPTH=8, rx_ready=0, send 10 bytes -> fifo_level=8, overflow=1, drop_count=2; the popped sequence is the first 8 bytes.
- FIFO full with rx_ready pulsed on the edge of a strobe -> no drop, fifo_level stays 8, the new byte is queued last.
- Send 300 bytes into a full FIFO -> drop_count=255 (saturated); clr_ovf pulsed on an edge with a drop -> overflow=1, drop_count=1.
- CM_RX_LED_EN defined: accept 8'h3C -> LED=8'h3C; force an overflow -> LED=8'hFF until clr_ovf. Macro undefined -> LED=8'h00 throughout.

Source files
------------

// File: rtl/cm_rx_fifo.sv
// cm_rx_fifo: receive stage for the Xmega->FPGA byte interconnect.
// Samples CM[7:0] on each CLK_inter rising edge, resynchronises into CLK_50,
// and buffers bytes in a show-ahead FIFO drained over a valid/ready stream.
// Ports:
//   CLK_50, RST_n        system clock, async active-low reset
//   CM, CLK_inter        asynchronous data bus and byte strobe from the Xmega
//   rx_data, rx_valid,   head-of-FIFO stream; pop when rx_valid & rx_ready
//   rx_ready
//   fifo_level           occupancy 0..DEPTH
//   overflow, drop_count sticky drop flag and saturating drop counter
//   clr_ovf              synchronous clear of overflow/drop_count
//   LED                  debug view; built only with CM_RX_LED_EN defined
//                        (last accepted byte, 8'hFF while overflow), else 8'h00
module cm_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   CLK_50,
    input  logic                   RST_n,
    input  logic [7:0]             CM,
    input  logic                   CLK_inter,
    output logic [7:0]             rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    output logic [7:0]             drop_count,
    input  logic                   clr_ovf,
    output logic [7:0]             LED
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    cm_s1, cm_s2;
    logic          ck_s1, ck_s2, ck_s3, armed;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    mem [DEPTH];
    logic          strobe, pop, full, push, drop;

    assign strobe   = ck_s2 & ~ck_s3 & armed;
    assign pop      = rx_valid & rx_ready;
    assign full     = fifo_level == (AW+1)'(DEPTH);
    assign push     = strobe & (~full | pop);
    assign drop     = strobe & full & ~pop;
    assign rx_valid = fifo_level != '0;
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

    // Strobe synchroniser resets high so a CLK_inter held high through reset
    // never looks like a fresh low phase; armed only sets on a real low.
    always_ff @(posedge CLK_50 or negedge RST_n) begin
        if (!RST_n) begin
            cm_s1 <= 8'h00;
            cm_s2 <= 8'h00;
            ck_s1 <= 1'b1;
            ck_s2 <= 1'b1;
            ck_s3 <= 1'b1;
            armed <= 1'b0;
        end else begin
            cm_s1 <= CM;
            cm_s2 <= cm_s1;
            ck_s1 <= CLK_inter;
            ck_s2 <= ck_s1;
            ck_s3 <= ck_s2;
            armed <= armed | ~ck_s2;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK_50 or negedge RST_n) begin
        if (!RST_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge CLK_50) begin
        if (push) mem[wr_ptr] <= cm_s2;
    end

    // A drop on the clearing edge wins, leaving overflow=1, drop_count=1.
    always_ff @(posedge CLK_50 or negedge RST_n) begin
        if (!RST_n) begin
            overflow   <= 1'b0;
            drop_count <= 8'h00;
        end else begin
            overflow   <= clr_ovf ? drop : (overflow | drop);
            drop_count <= clr_ovf ? {7'd0, drop} :
                          (drop && drop_count != 8'hFF) ? drop_count + 8'd1 : drop_count;
        end
    end

`ifdef CM_RX_LED_EN
    logic [7:0] led_q;
    always_ff @(posedge CLK_50 or negedge RST_n) begin
        if (!RST_n) led_q <= 8'h00;
        else if (push) led_q <= cm_s2;
    end
    assign LED = overflow ? 8'hFF : led_q;
`else
    assign LED = 8'h00;
`endif
endmodule

// File: tb/tb_cm_rx_fifo.sv
// tb_cm_rx_fifo: scoreboard bench for cm_rx_fifo with a queue-based reference model.
module tb_cm_rx_fifo;
    localparam int DEPTH = 8;

    logic       CLK_50 = 1'b0;
    logic       RST_n = 1'b0;
    logic [7:0] CM = 8'h00;
    logic       CLK_inter = 1'b1;
    logic       rx_ready = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [$clog2(DEPTH):0] fifo_level;
    logic       overflow;
    logic [7:0] drop_count;
    logic [7:0] LED;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];
    bit   exp_ovf = 1'b0;
    int   exp_drops = 0;
    logic [7:0] last_acc = 8'h00;
    bit   mon_on = 1'b0;
    bit   rand_on = 1'b0;

    cm_rx_fifo #(.DEPTH(DEPTH)) dut (
        .CLK_50(CLK_50), .RST_n(RST_n), .CM(CM), .CLK_inter(CLK_inter),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count),
        .clr_ovf(clr_ovf), .LED(LED)
    );

    always #10 CLK_50 = ~CLK_50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] exp_led();
`ifdef CM_RX_LED_EN
        return exp_ovf ? 8'hFF : last_acc;
`else
        return 8'h00;
`endif
    endfunction

    // Monitor: at each negedge the inputs seen by the next posedge are settled,
    // so a valid&ready here is a pop that the scoreboard must account for.
    always @(negedge CLK_50) begin
        if (mon_on) begin
            check("level", 32'(fifo_level), 32'(exp_q.size()));
            check("valid", 32'(rx_valid), 32'(exp_q.size() != 0));
            check("overflow", 32'(overflow), 32'(exp_ovf));
            check("drop_count", 32'(drop_count), 32'(exp_drops));
            check("led", 32'(LED), 32'(exp_led()));
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) check("unexpected_pop", 32'(rx_data), 32'hFFFF_FFFF);
                else check("data", 32'(rx_data), 32'(exp_q.pop_front()));
            end else if (!rx_valid) begin
                check("data_empty", 32'(rx_data), 32'h0);
            end
        end
    end

    // One Xmega byte transfer obeying the setup/hold/phase rules.
    task automatic send(input logic [7:0] b, input bit pulse, input bit clr);
        bit dropped;
        @(posedge CLK_50);
        #1 CM = b;
        repeat (3) @(posedge CLK_50);
        #1 CLK_inter = 1'b1;
        repeat (2) @(posedge CLK_50);
        #1;
        if (pulse) rx_ready = 1'b1;
        if (clr) clr_ovf = 1'b1;
        @(posedge CLK_50);
        #1;
        if (pulse) rx_ready = 1'b0;
        clr_ovf = 1'b0;
        dropped = exp_q.size() >= DEPTH;
        if (!dropped) begin
            exp_q.push_back(b);
            last_acc = b;
        end
        if (clr) begin
            exp_ovf = dropped;
            exp_drops = dropped ? 1 : 0;
        end else if (dropped) begin
            exp_ovf = 1'b1;
            exp_drops = (exp_drops < 255) ? exp_drops + 1 : 255;
        end
        repeat (2) @(posedge CLK_50);
        #1 CLK_inter = 1'b0;
        repeat (3) @(posedge CLK_50);
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(posedge CLK_50);
        #1 rx_ready = 1'b1;
        while ((exp_q.size() != 0 || rx_valid) && n < 40) begin
            @(posedge CLK_50);
            n++;
        end
        #1;
        check("drain_timeout", 32'(n < 40), 32'h1);
        rx_ready = 1'b0;
    endtask

    task automatic clear();
        @(posedge CLK_50);
        #1 clr_ovf = 1'b1;
        @(posedge CLK_50);
        #1 clr_ovf = 1'b0;
        exp_ovf = 1'b0;
        exp_drops = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (4) @(posedge CLK_50);
        #1;
        check("rst_valid", 32'(rx_valid), 32'h0);
        check("rst_level", 32'(fifo_level), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_drops", 32'(drop_count), 32'h0);
        check("rst_led", 32'(LED), 32'h0);
        check("rst_data", 32'(rx_data), 32'h0);
        RST_n = 1'b1;
        mon_on = 1'b1;
        repeat (20) @(posedge CLK_50);
        #1;
        check("held_high_valid", 32'(rx_valid), 32'h0);
        CLK_inter = 1'b0;
        repeat (3) @(posedge CLK_50);
        send(8'hA5, 1'b0, 1'b0);
        check("first_valid", 32'(rx_valid), 32'h1);
        check("first_data", 32'(rx_data), 32'hA5);
        drain();

        for (int i = 1; i <= 5; i++) send(8'(i), 1'b0, 1'b0);
        check("five_level", 32'(fifo_level), 32'h5);
        drain();
        check("five_empty", 32'(rx_valid), 32'h0);

        for (int i = 0; i < 10; i++) send(8'($urandom), 1'b0, 1'b0);
        check("ovf_level", 32'(fifo_level), 32'h8);
        check("ovf_flag", 32'(overflow), 32'h1);
        check("ovf_drops", 32'(drop_count), 32'h2);
        send(8'hEE, 1'b1, 1'b0);
        check("simul_level", 32'(fifo_level), 32'h8);
        check("simul_drops", 32'(drop_count), 32'h2);
        drain();
        clear();

        send(8'h3C, 1'b0, 1'b0);
        drain();

        for (int i = 0; i < 300; i++) send(8'($urandom), 1'b0, 1'b0);
        check("sat_drops", 32'(drop_count), 32'd255);
        send(8'h77, 1'b0, 1'b1);
        check("clr_drop_ovf", 32'(overflow), 32'h1);
        check("clr_drop_cnt", 32'(drop_count), 32'h1);
        drain();
        clear();

        rand_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 80; i++) send(8'($urandom), 1'b0, 1'b0);
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge CLK_50);
                    #1 rx_ready = ($urandom_range(0, 3) == 0);
                end
            end
        join
        drain();
        clear();

        for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0, 1'b0);
        @(posedge CLK_50);
        #5 mon_on = 1'b0;
        RST_n = 1'b0;
        #1;
        check("midrst_valid", 32'(rx_valid), 32'h0);
        check("midrst_level", 32'(fifo_level), 32'h0);
        check("midrst_data", 32'(rx_data), 32'h0);
        check("midrst_led", 32'(LED), 32'h0);
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_drops = 0;
        last_acc = 8'h00;
        @(posedge CLK_50);
        #1 RST_n = 1'b1;
        mon_on = 1'b1;
        repeat (3) @(posedge CLK_50);
        send(8'h5A, 1'b0, 1'b0);
        check("post_rst_data", 32'(rx_data), 32'h5A);
        drain();

        mon_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
